dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the microcoded Y86-64 core. It is the slave side of the DMemReady handshake that the microsequencer waits on: it latches a read or write request from the control datapath, inserts configurable wait states, and performs the 8-byte little-endian access against an internal word array. Unaligned addresses are serviced in two word beats. It then returns a one-cycle ready pulse with read data or an address-error flag.

## Interface
- `DEPTH_WORDS`, default 1024: number of 64-bit words in the backing array; valid byte addresses are 0 .. DEPTH_WORDS*8-1.
- `WAIT_STATES`, default 2: extra idle cycles inserted before the first array beat; 0 is legal.
- `clk`  in  1  single system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `memRead`  in  1  read request; level, held by control until ready.
- `memWrite`  in  1  write request; level, held by control until ready.
- `addr`  in  64  byte address of the quadword.
- `wdata`  in  64  write data, little-endian.
- `rdata`  out  64  read data; valid only while DMemReady=1.
- `DMemReady`  out  1  one-cycle completion pulse.
- `memError`  out  1  qualifies DMemReady; 1 = address error (Y86 ADR status).

## Operation
- Reset values: `DMemReady`=0, `memError`=0, `rdata`=0, state IDLE, counter 0. Array contents are not reset.
- States: IDLE, WAIT, BEAT0, BEAT1, DONE.
- IDLE:
  - When exactly one of memRead/memWrite is 1, latch op, addr and wdata, load the counter with WAIT_STATES, and go to WAIT.
  - Both high, or addr+7 ≥ DEPTH_WORDS*8 (64-bit compare, no wrap), goes straight to DONE with error set.
  - Neither high: stay in IDLE.
- WAIT: decrement the counter. At counter 0, go to BEAT0.
- BEAT0: access word addr[..:3].
  - Aligned (addr[2:0]=0): a read captures the full word; a write stores all 8 bytes. Go to DONE.
  - Unaligned: a read captures the upper 8-off bytes into rdata low bytes; a write stores wdata low bytes into the word's upper bytes under a byte mask. Go to BEAT1.
- BEAT1: access word+1 for the remaining off bytes (read into rdata high bytes; masked write of the wdata high bytes). Go to DONE.
- DONE: DMemReady=1 for exactly one cycle, memError per latch, rdata final (0 on error or write). Always returns to IDLE.
- Requests are sampled only in IDLE. Input changes after latching are ignored, and the operation completes with the latched values.
- The request still being high in the cycle after DONE is treated as a new request.
- An errored access never modifies the array.
- Reset mid-operation returns to IDLE immediately. If the write has not reached BEAT0, the array is untouched; if BEAT0 is done but BEAT1 is not, the write is partial. The control unit treats reset as abandoning the access.

## Timing
- The request is first high in cycle t, when the block is in IDLE.
- Aligned access: DMemReady high in cycle t+WAIT_STATES+3 (W=0: t+3).
- Unaligned access: one cycle later than aligned.
- Error: DMemReady high in cycle t+1.
- Back-to-back: the minimum gap between ready pulses is one IDLE cycle plus the access latency. There is no pipelining; one outstanding access at a time.
- DMemReady is registered, so there is no combinational path from the request inputs to the outputs.

## Structure
- Package `y86_mem_pkg`:
  - state enum
  - `WORD_BYTES`=8
  - status constants (AOK, ADR)
  - a byte-mask generation function from offset and beat
- Sub-module `dmem_array`: DEPTH_WORDS×64, asynchronous read, synchronous write with 8-bit byte-enable. The responder contains the FSM, counter, latches and merge logic.

## Test plan
- Aligned write then read: W=2, write addr 0x10 data 0x1122334455667788, then read 0x10.
  - Write ready at t+5, memError=0.
  - Read ready at t+5, rdata=0x1122334455667788.
- Unaligned: write 0x0807060504030201 at addr 0x0D, then read 0x08 and 0x10.
  - The write ready pulse comes one cycle later than aligned.
  - Word 0x08 upper bytes = 0x030201.
  - Word 0x10 low bytes = 0x0807060504.
  - Reading 0x0D returns the original value.
- Address error: read at DEPTH_WORDS*8-4, and separately memRead and memWrite both high.
  - Ready at t+1, memError=1, rdata=0.
  - No array change.
- Held request: keep memRead high for 10 cycles with W=0.
  - Ready pulses at t+3 and t+7, each exactly one cycle wide.
- Reset mid-operation: assert rst_n=0 during WAIT of a write, release, then read the same address.
  - DMemReady=0 during reset.
  - The old data is returned.

Source files
------------

// File: rtl/y86_mem_pkg.sv
// rtl/y86_mem_pkg.sv - shared types, constants and byte-mask helper for the data-memory responder
package y86_mem_pkg;

  localparam int WORD_BYTES = 8;

  // Y86 status codes carried back with the completion pulse
  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] ADR = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_BEAT0,
    S_BEAT1,
    S_DONE
  } state_t;

  // Beat 0 covers bytes off..7 of the first word, beat 1 covers bytes 0..off-1 of the next word
  function automatic logic [WORD_BYTES-1:0] byte_mask(input logic [2:0] off, input logic beat);
    logic [WORD_BYTES-1:0] upper;
    upper = 8'hFF << off;
    return beat ? ~upper : upper;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bundle between control datapath and memory responder
interface dmem_responder_if;
  logic        memRead;
  logic        memWrite;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        DMemReady;
  logic        memError;

  modport master (
    output memRead, memWrite, addr, wdata,
    input  rdata, DMemReady, memError
  );

  modport slave (
    input  memRead, memWrite, addr, wdata,
    output rdata, DMemReady, memError
  );
endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array with asynchronous read and byte-enabled synchronous write
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] idx,
  output logic [63:0]   rd_word,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [63:0]   wr_word
);

  logic [63:0] mem [DEPTH_WORDS];

  assign rd_word = mem[idx];

  // Store only the enabled byte lanes; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - DMemReady slave: latches a request, waits, runs one or two word beats, pulses ready
module dmem_responder
  import y86_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [64:0] LIMIT = 65'(DEPTH_WORDS) << 3;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic          op_write;
  logic [AW+2:0] addr_q;
  logic [63:0]   wdata_q;
  logic [2:0]    stat_q;
  logic [63:0]   acc;
  logic          ready_q;

  logic          req_any;
  logic          req_both;
  logic [64:0]   addr_end;
  logic          addr_bad;
  logic [2:0]    off;
  logic [2:0]    rem;
  logic [AW-1:0] word_idx;

  logic [AW-1:0] mem_idx;
  logic          mem_we;
  logic [7:0]    mem_be;
  logic [63:0]   mem_wdata;
  logic [63:0]   rd_word;

  assign req_any  = bus.memRead | bus.memWrite;
  assign req_both = bus.memRead & bus.memWrite;
  // 65-bit sum so an address near 2^64 cannot wrap into the valid range
  assign addr_end = {1'b0, bus.addr} + 65'd7;
  assign addr_bad = (addr_end >= LIMIT);

  assign off      = addr_q[2:0];
  assign rem      = 3'(4'd8 - {1'b0, off});
  assign word_idx = addr_q[AW+2:3];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state decode and array beat controls
  always_comb begin
    next_state = state;
    mem_idx    = word_idx;
    mem_we     = 1'b0;
    mem_be     = 8'h00;
    mem_wdata  = 64'd0;
    case (state)
      S_IDLE: begin
        if (req_any) begin
          if (req_both || addr_bad) next_state = S_DONE;
          else                      next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) next_state = S_BEAT0;
      end
      S_BEAT0: begin
        mem_we     = op_write;
        mem_be     = byte_mask(off, 1'b0);
        mem_wdata  = wdata_q << {off, 3'b000};
        next_state = (off == 3'd0) ? S_DONE : S_BEAT1;
      end
      S_BEAT1: begin
        mem_idx    = word_idx + AW'(1);
        mem_we     = op_write;
        mem_be     = byte_mask(off, 1'b1);
        mem_wdata  = wdata_q >> {rem, 3'b000};
        next_state = S_DONE;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Request latch, wait counter, read-data merge and the registered ready pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 64'd0;
      stat_q   <= AOK;
      acc      <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= (next_state == S_DONE);
      case (state)
        S_IDLE: begin
          if (req_any) begin
            op_write <= bus.memWrite;
            addr_q   <= bus.addr[AW+2:0];
            wdata_q  <= bus.wdata;
            cnt      <= CW'(WAIT_STATES);
            stat_q   <= (req_both || addr_bad) ? ADR : AOK;
            acc      <= 64'd0;
          end
        end
        S_WAIT: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        S_BEAT0: begin
          if (!op_write) acc <= rd_word >> {off, 3'b000};
        end
        S_BEAT1: begin
          if (!op_write) acc <= acc | (rd_word << {rem, 3'b000});
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rdata     = acc;
  assign bus.DMemReady = ready_q;
  assign bus.memError  = ready_q & (stat_q == ADR);

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .idx    (mem_idx),
    .rd_word(rd_word),
    .we     (mem_we),
    .be     (mem_be),
    .wr_word(mem_wdata)
  );

endmodule
